hci_core_id_tagger: RTL and testbench



---
 rtl/hci_core_id_tagger_pkg.sv | 23 ++
 rtl/hci_core_id_tagger_if.sv | 35 +++
 rtl/hci_core_id_tagger_credit_counter.sv | 40 ++++
 rtl/hci_core_id_tagger.sv | 111 +++++++++++
 tb/tb_hci_core_id_tagger.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/hci_core_id_tagger_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hci_core_id_tagger_pkg
// Brief    : Error codes and user-field packing helper for the ID tagger.
// Revision : 1.0 - initial release
// ============================================================================
package hci_core_id_tagger_pkg;

    typedef logic [1:0] hci_tag_err_t;

    localparam hci_tag_err_t HCI_TAG_ERR_NONE  = 2'd0;
    localparam hci_tag_err_t HCI_TAG_ERR_UNEXP = 2'd1;
    localparam hci_tag_err_t HCI_TAG_ERR_SEQ   = 2'd2;

    // Builds the integer value of a {id, seq} user field.
    function automatic int unsigned hci_tag_user(input int unsigned id,
                                                 input int unsigned seq,
                                                 input int unsigned seq_w);
        return (id << seq_w) | (seq & ((32'd1 << seq_w) - 32'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hci_core_id_tagger_if.sv
`default_nettype none
// ============================================================================
// Module   : hci_core_intf
// Brief    : TCDM request/response bundle with initiator and target views.
// Revision : 1.0 - initial release
// ============================================================================
interface hci_core_intf #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int UW = 2
) ();
    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] be;
    logic [UW-1:0]   user;
    logic            r_valid;
    logic [DW-1:0]   r_data;
    logic            r_opc;
    logic [UW-1:0]   r_user;
    logic            lrdy;

    modport initiator (
        output req, add, wen, data, be, user, lrdy,
        input  gnt, r_valid, r_data, r_opc, r_user
    );

    modport target (
        input  req, add, wen, data, be, user, lrdy,
        output gnt, r_valid, r_data, r_opc, r_user
    );
endinterface
`default_nettype wire

// File: rtl/hci_core_id_tagger_credit_counter.sv
`default_nettype none
// ============================================================================
// Module   : hci_tag_credit_counter
// Brief    : Up/down in-flight counter with full and empty flags.
// Revision : 1.0 - initial release
// ============================================================================
module hci_tag_credit_counter #(
    parameter int MAX = 2
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_clear,
    input  wire logic                       i_inc,
    input  wire logic                       i_dec,
    output logic [$clog2(MAX+1)-1:0]        o_count,
    output logic                            o_full,
    output logic                            o_empty
);
    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] r_count;

    // Callers never increment when full or decrement when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            r_count <= r_count + CW'(1);
        end else if (i_dec && !i_inc) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == CW'(MAX));
    assign o_empty = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/hci_core_id_tagger.sv
`default_nettype none
// ============================================================================
// Module   : hci_core_id_tagger
// Brief    : Stamps requests with {ID, seq}, limits in-flight count and
//            filters/checks returning responses by ID and sequence.
// Revision : 1.0 - initial release
// ============================================================================
module hci_core_id_tagger
    import hci_core_id_tagger_pkg::*;
#(
    parameter int DW              = 32,
    parameter int ID_W            = 1,
    parameter int SEQ_W           = 1,
    parameter int ID              = 0,
    parameter int MAX_OUTSTANDING = 2
) (
    input  wire logic                               clk_i,
    input  wire logic                               rst_i,
    input  wire logic                               clear_i,
    hci_core_intf.target                            tcdm_slave,
    hci_core_intf.initiator                         tcdm_master,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    outstanding_o,
    output logic                                    busy_o,
    output logic                                    err_o,
    output logic [1:0]                              err_code_o
);
    localparam int UW    = ID_W + SEQ_W;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] w_cnt;
    logic             w_full;
    logic             w_empty;
    logic [SEQ_W-1:0] r_seq_tx;
    logic [SEQ_W-1:0] r_seq_rx;
    logic             r_err;
    hci_tag_err_t     r_code;
    logic             w_accept;
    logic             w_hit;
    logic             w_fwd;
    logic             w_consume;
    logic             w_unexp;
    logic             w_seq_bad;

    // full comes from the registered count only, so r_valid never reaches gnt.
    assign tcdm_master.req  = tcdm_slave.req & ~w_full;
    assign tcdm_slave.gnt   = tcdm_master.gnt & ~w_full;
    assign tcdm_master.add  = tcdm_slave.add;
    assign tcdm_master.wen  = tcdm_slave.wen;
    assign tcdm_master.be   = tcdm_slave.be;
    assign tcdm_master.data = tcdm_slave.data;
    assign tcdm_master.user = {ID_W'(ID), r_seq_tx};

    assign w_accept = tcdm_slave.req & tcdm_master.gnt & ~w_full;

    assign w_hit     = tcdm_master.r_valid & (tcdm_master.r_user[UW-1:SEQ_W] == ID_W'(ID));
    assign w_fwd     = w_hit & ~w_empty;
    assign w_consume = w_fwd & tcdm_slave.lrdy;
    assign w_unexp   = w_hit & w_empty;
    assign w_seq_bad = w_fwd & (tcdm_master.r_user[SEQ_W-1:0] != r_seq_rx);

    assign tcdm_slave.r_valid = w_fwd;
    assign tcdm_slave.r_data  = tcdm_master.r_data;
    assign tcdm_slave.r_opc   = tcdm_master.r_opc;
    assign tcdm_slave.r_user  = tcdm_master.r_user;
    assign tcdm_master.lrdy   = tcdm_slave.lrdy;

    hci_tag_credit_counter #(
        .MAX (MAX_OUTSTANDING)
    ) u_credit (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_clear (clear_i),
        .i_inc   (w_accept),
        .i_dec   (w_consume),
        .o_count (w_cnt),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // The first error is latched and held until reset or clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_seq_tx <= '0;
            r_seq_rx <= '0;
            r_err    <= 1'b0;
            r_code   <= HCI_TAG_ERR_NONE;
        end else if (clear_i) begin
            r_seq_tx <= '0;
            r_seq_rx <= '0;
            r_err    <= 1'b0;
            r_code   <= HCI_TAG_ERR_NONE;
        end else begin
            if (w_accept) begin
                r_seq_tx <= r_seq_tx + SEQ_W'(1);
            end
            if (w_consume) begin
                r_seq_rx <= r_seq_rx + SEQ_W'(1);
            end
            if (!r_err && (w_unexp || w_seq_bad)) begin
                r_err  <= 1'b1;
                r_code <= w_unexp ? HCI_TAG_ERR_UNEXP : HCI_TAG_ERR_SEQ;
            end
        end
    end

    assign outstanding_o = w_cnt;
    assign busy_o        = ~w_empty;
    assign err_o         = r_err;
    assign err_code_o    = r_code;
endmodule
`default_nettype wire

// File: tb/tb_hci_core_id_tagger.sv
`default_nettype none
// ============================================================================
// Module   : tb_hci_core_id_tagger
// Brief    : Directed plus randomized bench against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hci_core_id_tagger;
    import hci_core_id_tagger_pkg::*;

    localparam int DW    = 32;
    localparam int ID_W  = 1;
    localparam int SEQ_W = 1;
    localparam int ID    = 1;
    localparam int MAX   = 2;
    localparam int UW    = ID_W + SEQ_W;
    localparam int CW    = $clog2(MAX + 1);
    localparam int NSEQ  = 1 << SEQ_W;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic [CW-1:0] outstanding;
    logic busy;
    logic err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    hci_core_intf #(.DW(DW), .AW(32), .UW(UW)) s_if ();
    hci_core_intf #(.DW(DW), .AW(32), .UW(UW)) m_if ();

    hci_core_id_tagger #(
        .DW              (DW),
        .ID_W            (ID_W),
        .SEQ_W           (SEQ_W),
        .ID              (ID),
        .MAX_OUTSTANDING (MAX)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clear),
        .tcdm_slave    (s_if),
        .tcdm_master   (m_if),
        .outstanding_o (outstanding),
        .busy_o        (busy),
        .err_o         (err),
        .err_code_o    (err_code)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: in-flight count, next seq to send/expect, first error.
    int m_cnt = 0;
    int m_tx  = 0;
    int m_rx  = 0;
    int m_err = 0;
    int m_code = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_tx = 0; m_rx = 0; m_err = 0; m_code = 0;
    endtask

    // One clock: drive at posedge+1, check at posedge+4, update model, advance.
    task automatic step(input bit req, input bit gnt, input bit rv,
                        input int unsigned ruser, input bit lrdy, input bit clr);
        bit full, hit, fwd, acc, con;
        int unsigned exp_user;
        s_if.req    = req;
        s_if.add    = $urandom;
        s_if.wen    = 1'($urandom);
        s_if.data   = $urandom;
        s_if.be     = 4'($urandom);
        s_if.user   = 2'($urandom);
        s_if.lrdy   = lrdy;
        m_if.gnt    = gnt;
        m_if.r_valid = rv;
        m_if.r_user = UW'(ruser);
        m_if.r_data = $urandom;
        m_if.r_opc  = 1'($urandom);
        clear       = clr;
        #3;
        full     = (m_cnt == MAX);
        hit      = rv && ((ruser >> SEQ_W) == ID);
        fwd      = hit && (m_cnt > 0);
        exp_user = hci_tag_user(ID, m_tx, SEQ_W);
        check("m_req",     m_if.req,  req && !full);
        check("s_gnt",     s_if.gnt,  gnt && !full);
        check("m_user",    m_if.user, exp_user);
        check("m_add",     m_if.add,  s_if.add);
        check("m_data",    {m_if.wen, m_if.be, m_if.data}, {s_if.wen, s_if.be, s_if.data});
        check("s_rvalid",  s_if.r_valid, fwd);
        check("s_rdata",   {s_if.r_opc, s_if.r_user, s_if.r_data}, {m_if.r_opc, m_if.r_user, m_if.r_data});
        check("m_lrdy",    m_if.lrdy, lrdy);
        check("outstanding", outstanding, m_cnt);
        check("busy",      busy, m_cnt != 0);
        check("err",       err, m_err);
        check("err_code",  err_code, m_code);
        if (clr) begin
            model_reset();
        end else begin
            acc = req && gnt && !full;
            con = fwd && lrdy;
            if (hit && m_err == 0) begin
                if (m_cnt == 0) begin
                    m_err = 1; m_code = 1;
                end else if ((ruser % NSEQ) != m_rx) begin
                    m_err = 1; m_code = 2;
                end
            end
            m_cnt = m_cnt + int'(acc) - int'(con);
            if (acc) m_tx = (m_tx + 1) % NSEQ;
            if (con) m_rx = (m_rx + 1) % NSEQ;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned ru;
        int unsigned s0;
        int pick;
        rst = 1'b1;
        clear = 1'b0;
        s_if.req = 0; s_if.add = 0; s_if.wen = 0; s_if.data = 0; s_if.be = 0;
        s_if.user = 0; s_if.lrdy = 0;
        m_if.gnt = 0; m_if.r_valid = 0; m_if.r_data = 0; m_if.r_opc = 0; m_if.r_user = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outstanding", outstanding, 0);
        check("rst_flags", {busy, err, err_code}, 4'b0000);
        rst = 1'b0;
        model_reset();

        // Three back-to-back reads, no responses: third is blocked.
        repeat (3) step(1, 1, 0, 0, 1, 0);
        check("plan_full", outstanding, 2);
        // Response {1,0} while full; pending request goes next cycle with seq 0.
        step(1, 1, 1, hci_tag_user(ID, 0, SEQ_W), 1, 0);
        check("plan_after_rsp", outstanding, 1);
        step(1, 1, 0, 0, 1, 0);
        // Foreign ID responses are ignored.
        step(0, 1, 1, hci_tag_user(0, 0, SEQ_W), 1, 0);
        step(0, 1, 1, hci_tag_user(0, 1, SEQ_W), 1, 0);
        check("plan_foreign", {outstanding, err}, {2'd2, 1'b0});
        // Drain in order: seq 1 then seq 0.
        step(0, 0, 1, hci_tag_user(ID, 1, SEQ_W), 1, 0);
        step(0, 0, 1, hci_tag_user(ID, 0, SEQ_W), 1, 0);
        // Unexpected response while idle.
        step(0, 0, 1, hci_tag_user(ID, 0, SEQ_W), 1, 0);
        check("plan_unexp", {err, err_code}, {1'b1, 2'd1});
        // A later sequence mismatch keeps the first code.
        step(1, 1, 0, 0, 1, 0);
        step(0, 0, 1, hci_tag_user(ID, m_rx + 1, SEQ_W), 1, 0);
        check("plan_sticky", err_code, 1);
        step(0, 0, 0, 0, 1, 1);
        // Two outstanding, returned out of order.
        repeat (2) step(1, 1, 0, 0, 1, 0);
        s0 = m_rx;
        step(0, 0, 1, hci_tag_user(ID, s0 + 1, SEQ_W), 1, 0);
        check("plan_seq_code", err_code, 2);
        step(0, 0, 1, hci_tag_user(ID, s0, SEQ_W), 1, 0);
        check("plan_seq_drain", {outstanding, err_code}, {2'd0, 2'd2});
        // Asynchronous reset with two in flight.
        step(0, 0, 0, 0, 1, 1);
        repeat (2) step(1, 1, 0, 0, 1, 0);
        rst = 1'b1;
        #2;
        check("async_rst", {outstanding, busy, err, err_code}, 6'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 1, hci_tag_user(ID, 0, SEQ_W), 1, 0);
        check("rst_forgets", {outstanding, err, err_code}, {2'd0, 1'b1, 2'd1});

        // Randomized traffic, mostly well-formed responses.
        for (int i = 0; i < 1500; i++) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 70)      ru = hci_tag_user(ID, m_rx, SEQ_W);
            else if (pick < 85) ru = hci_tag_user(ID, $urandom, SEQ_W);
            else                ru = hci_tag_user(ID ^ 1, $urandom, SEQ_W);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 1) == 1, ru, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
